// File: rtl/pit_timer_bank.sv
// pit_timer_bank: bank of 8254-style down-counters on the data-master I/O bus.
// Optional feature macro PIT_STATUS_READBACK_EN: control reads return channel status.
module pit_timer_bank #(
    parameter int NUM_CHANNELS = 3,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pit_clk,
    input  logic                    cs,
    input  logic [2:0]              data_m_addr,
    input  logic [15:0]             data_m_data_in,
    output logic [15:0]             data_m_data_out,
    input  logic [1:0]              data_m_bytesel,
    input  logic                    data_m_wr_en,
    input  logic                    data_m_access,
    output logic                    data_m_ack,
    input  logic [NUM_CHANNELS-1:0] gate,
    output logic [NUM_CHANNELS-1:0] out
);
    localparam int CW = COUNT_WIDTH;
    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [2:0]              r_pit_sync;
    logic                    w_tick;
    logic                    w_req;
    logic                    w_ctl_sel;
    logic                    w_ctl_wr;
    logic [31:0]             w_addr;
    logic [31:0]             w_idx;
    logic [NUM_CHANNELS-1:0] w_cfg;
    logic [NUM_CHANNELS-1:0] w_lat;
    logic [NUM_CHANNELS-1:0] w_wr_ch;
    logic [NUM_CHANNELS-1:0] w_rd_ch;
    logic [7:0]              w_byte [NUM_CHANNELS];
    logic [15:0]             w_rdata;
    logic                    w_unused;

    assign w_unused  = data_m_bytesel[1];
    assign w_tick    = r_pit_sync[1] & ~r_pit_sync[2];
    assign w_req     = cs & data_m_access & data_m_bytesel[0];
    assign w_addr    = {29'd0, data_m_addr};
    assign w_idx     = {24'd0, data_m_data_in[15:8]};
    assign w_ctl_sel = w_req && (w_addr == 32'(NUM_CHANNELS));
    assign w_ctl_wr  = w_ctl_sel & data_m_wr_en;

    // Two-flop synchroniser plus one stage of history for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_pit_sync <= 3'b000;
        else          r_pit_sync <= {r_pit_sync[1:0], pit_clk};
    end

    // Steer bus accesses into per-channel strobes
    always_comb begin
        w_cfg   = '0;
        w_lat   = '0;
        w_wr_ch = '0;
        w_rd_ch = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_ctl_wr && (w_idx == 32'(i))) begin
                if (data_m_data_in[5:4] == 2'b00) w_lat[i] = 1'b1;
                else                              w_cfg[i] = 1'b1;
            end
            if (w_req && (w_addr == 32'(i))) begin
                w_wr_ch[i] = data_m_wr_en;
                w_rd_ch[i] = ~data_m_wr_en;
            end
        end
    end

`ifdef PIT_STATUS_READBACK_EN
    logic [7:0] w_stat [NUM_CHANNELS];
    logic [2:0] r_stat_idx;

    // Remember which channel the last valid control write named
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stat_idx <= 3'd0;
        else if (w_ctl_wr && (w_idx < 32'(NUM_CHANNELS)))
            r_stat_idx <= data_m_data_in[10:8];
    end
`endif

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [CW-1:0] r_count;
        logic [CW-1:0] r_reload;
        logic [CW-1:0] r_latch_val;
        logic [7:0]    r_lsb;
        logic [1:0]    r_rw;
        logic [2:0]    r_mode;
        logic          r_null;
        logic          r_run;
        logic          r_pend;
        logic          r_wff;
        logic          r_rff;
        logic          r_latched;
        logic          r_out;
        logic          r_gate_d;
        logic          w_per;
        logic          w_m2;
        logic          w_grise;
        logic          w_wdone;
        logic          w_out_nxt;
        logic [15:0]   w_wval;
        logic [15:0]   w_src;
        logic [7:0]    w_rbyte;
        logic [CW-1:0] w_cnt_nxt;
        logic [CW-1:0] w_dec;
        logic [CW:0]   w_n;
        logic [CW:0]   w_nx;

        // Modes 2/6 rate, 3/7 square, everything else terminal count
        assign w_m2    = (r_mode[1:0] == 2'b10);
        assign w_per   = r_mode[1];
        assign w_grise = gate[g] & ~r_gate_d;
        assign w_dec   = r_count - C_ONE;
        assign w_n     = {r_reload == '0, r_reload};
        assign w_nx    = {w_dec == '0, w_dec};
        assign w_src   = 16'(r_latched ? r_latch_val : r_count);
        assign w_byte[g] = w_rbyte;
        assign out[g]  = r_out;

`ifdef PIT_STATUS_READBACK_EN
        assign w_stat[g] = {r_out, r_null, r_rw, r_mode, 1'b0};
`else
        logic w_unused_mode;
        assign w_unused_mode = r_mode[2];
`endif

        // Next count and output level for this cycle
        always_comb begin
            w_cnt_nxt = r_count;
            w_out_nxt = r_out;
            if (w_tick && r_pend) begin
                w_cnt_nxt = r_reload;
                w_out_nxt = w_per;
            end else if (w_tick && r_run && gate[g]) begin
                if (!w_per) begin
                    w_cnt_nxt = w_dec;
                    if (r_count == C_ONE) w_out_nxt = 1'b1;
                end else if (r_count == C_ONE) begin
                    w_cnt_nxt = r_reload;
                    w_out_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_dec;
                    w_out_nxt = w_m2 ? (w_dec != C_ONE)
                                     : (w_nx > (w_n >> 1));
                end
            end
            if (w_per && r_run && !gate[g]) w_out_nxt = 1'b1;
        end

        // Assemble the reload from the byte(s) written under the current rw
        always_comb begin
            w_wval  = 16'd0;
            w_wdone = 1'b0;
            case (r_rw)
                2'b01: begin
                    w_wval  = {8'd0, data_m_data_in[7:0]};
                    w_wdone = 1'b1;
                end
                2'b10: begin
                    w_wval  = {data_m_data_in[7:0], 8'd0};
                    w_wdone = 1'b1;
                end
                2'b11: begin
                    w_wval  = {data_m_data_in[7:0], r_lsb};
                    w_wdone = r_wff;
                end
                default: ;
            endcase
        end

        // Byte presented to a channel read
        always_comb begin
            w_rbyte = w_src[7:0];
            if ((r_rw == 2'b10) || ((r_rw == 2'b11) && r_rff))
                w_rbyte = w_src[15:8];
        end

        // Channel state: counting, latching, byte sequencing, config
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_count     <= '0;
                r_reload    <= '0;
                r_latch_val <= '0;
                r_lsb       <= 8'd0;
                r_rw        <= 2'b11;
                r_mode      <= 3'd0;
                r_null      <= 1'b1;
                r_run       <= 1'b0;
                r_pend      <= 1'b0;
                r_wff       <= 1'b0;
                r_rff       <= 1'b0;
                r_latched   <= 1'b0;
                r_out       <= 1'b0;
                r_gate_d    <= 1'b0;
            end else begin
                r_gate_d <= gate[g];
                r_count  <= w_cnt_nxt;
                r_out    <= w_out_nxt;
                if (w_tick && r_pend) begin
                    r_pend <= 1'b0;
                    r_null <= 1'b0;
                    r_run  <= 1'b1;
                end
                if (w_per && w_grise && !r_null) r_pend <= 1'b1;
                if (w_lat[g] && !r_latched) begin
                    r_latched   <= 1'b1;
                    r_latch_val <= w_cnt_nxt;
                end
                if (w_rd_ch[g]) begin
                    if ((r_rw == 2'b11) && !r_rff) begin
                        r_rff <= 1'b1;
                    end else begin
                        r_rff     <= 1'b0;
                        r_latched <= 1'b0;
                    end
                end
                if (w_wr_ch[g]) begin
                    if ((r_rw == 2'b11) && !r_wff) begin
                        r_lsb <= data_m_data_in[7:0];
                        r_wff <= 1'b1;
                    end
                    if (w_wdone) begin
                        r_wff    <= 1'b0;
                        r_reload <= w_wval[CW-1:0];
                        r_pend   <= 1'b1;
                        if (!w_per) r_out <= 1'b0;
                    end
                end
                if (w_cfg[g]) begin
                    r_rw   <= data_m_data_in[5:4];
                    r_mode <= data_m_data_in[3:1];
                    r_null <= 1'b1;
                    r_run  <= 1'b0;
                    r_pend <= 1'b0;
                    r_wff  <= 1'b0;
                    r_rff  <= 1'b0;
                    r_out  <= 1'b0;
                end
            end
        end
    end

    // Read data source for this cycle's access
    always_comb begin
        w_rdata = 16'd0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (w_rd_ch[i]) w_rdata = {8'd0, w_byte[i]};
`ifdef PIT_STATUS_READBACK_EN
        if (w_ctl_sel && !data_m_wr_en)
            for (int i = 0; i < NUM_CHANNELS; i++)
                if ({29'd0, r_stat_idx} == 32'(i))
                    w_rdata = {8'd0, w_stat[i]};
`endif
    end

    // Registered bus response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_m_ack      <= 1'b0;
            data_m_data_out <= 16'd0;
        end else begin
            data_m_ack      <= cs & data_m_access;
            data_m_data_out <= w_rdata;
        end
    end
endmodule

// File: tb/tb_pit_timer_bank.sv
// tb_pit_timer_bank: directed checks of modes, latching, bus timing and reset.
module tb_pit_timer_bank;
    localparam int NCH = 3;
    localparam logic [2:0] CTL = 3'd3;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           pit_clk = 1'b0;
    logic           cs = 1'b0;
    logic [2:0]     data_m_addr = 3'd0;
    logic [15:0]    data_m_data_in = 16'd0;
    logic [15:0]    data_m_data_out;
    logic [1:0]     data_m_bytesel = 2'b11;
    logic           data_m_wr_en = 1'b0;
    logic           data_m_access = 1'b0;
    logic           data_m_ack;
    logic [NCH-1:0] gate = '1;
    logic [NCH-1:0] out;

    int n_run  = 0;
    int n_fail = 0;

    pit_timer_bank #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pit_clk(pit_clk),
        .cs(cs),
        .data_m_addr(data_m_addr),
        .data_m_data_in(data_m_data_in),
        .data_m_data_out(data_m_data_out),
        .data_m_bytesel(data_m_bytesel),
        .data_m_wr_en(data_m_wr_en),
        .data_m_access(data_m_access),
        .data_m_ack(data_m_ack),
        .gate(gate),
        .out(out)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
        data_m_addr = a; data_m_data_in = d;
        @(negedge clk);
        cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0;
        data_m_addr = a;
        @(negedge clk);
        d = data_m_data_out;
        cs = 1'b0; data_m_access = 1'b0;
    endtask

    task automatic read16(input logic [2:0] a, output logic [15:0] v);
        logic [15:0] lo;
        logic [15:0] hi;
        bus_read(a, lo);
        bus_read(a, hi);
        v = {hi[7:0], lo[7:0]};
    endtask

    // one pit_clk period; the counter updates 3 clk after the rising edge
    task automatic pit_tick();
        @(negedge clk); pit_clk = 1'b1;
        @(negedge clk);
        @(negedge clk); pit_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_run++;
        if (out !== 3'b000) begin
            n_fail++; $display("FAIL reset_out: got %b expected 000", out);
        end
        n_run++;
        if (data_m_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_ack: got %b expected 0", data_m_ack);
        end
        n_run++;
        if (data_m_data_out !== 16'd0) begin
            n_fail++; $display("FAIL reset_dout: got %h expected 0000", data_m_data_out);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [15:0] v;
        bus_write(CTL, 16'h0030);
        n_run++;
        if (out[0] !== 1'b0) begin
            n_fail++; $display("FAIL mode0_cfg_out: got %b expected 0", out[0]);
        end
        bus_write(3'd0, 16'h0005);
        bus_write(3'd0, 16'h0000);
        pit_tick();
        read16(3'd0, v);
        n_run++;
        if (v !== 16'h0005) begin
            n_fail++; $display("FAIL mode0_load: got %h expected 0005", v);
        end
        for (int i = 1; i <= 4; i++) begin
            pit_tick();
            n_run++;
            if (out[0] !== 1'b0) begin
                n_fail++; $display("FAIL mode0_pre_tc tick %0d: got %b expected 0", i, out[0]);
            end
        end
        @(negedge clk); pit_clk = 1'b1;
        @(negedge clk);
        @(negedge clk); pit_clk = 1'b0;
        n_run++;
        if (out[0] !== 1'b0) begin
            n_fail++; $display("FAIL mode0_edge_early: got %b expected 0", out[0]);
        end
        @(negedge clk);
        n_run++;
        if (out[0] !== 1'b1) begin
            n_fail++; $display("FAIL mode0_edge_3clk: got %b expected 1", out[0]);
        end
        @(negedge clk);
        pit_tick();
        n_run++;
        if (out[0] !== 1'b1) begin
            n_fail++; $display("FAIL mode0_stays: got %b expected 1", out[0]);
        end
        read16(3'd0, v);
        n_run++;
        if (v !== 16'hFFFF) begin
            n_fail++; $display("FAIL mode0_wrap: got %h expected ffff", v);
        end
        bus_write(3'd0, 16'h0005);
        bus_write(3'd0, 16'h0000);
        n_run++;
        if (out[0] !== 1'b0) begin
            n_fail++; $display("FAIL mode0_rearm: got %b expected 0", out[0]);
        end
    endtask

    task automatic test_mode2();
        logic [15:0] v;
        logic        e;
        bus_write(CTL, 16'h0134);
        bus_write(3'd1, 16'h0004);
        bus_write(3'd1, 16'h0000);
        pit_tick();
        n_run++;
        if (out[1] !== 1'b1) begin
            n_fail++; $display("FAIL mode2_load: got %b expected 1", out[1]);
        end
        for (int i = 0; i < 8; i++) begin
            pit_tick();
            e = ((i % 4) == 2) ? 1'b0 : 1'b1;
            n_run++;
            if (out[1] !== e) begin
                n_fail++; $display("FAIL mode2_pattern tick %0d: got %b expected %b", i, out[1], e);
            end
        end
        repeat (3) pit_tick();
        n_run++;
        if (out[1] !== 1'b0) begin
            n_fail++; $display("FAIL mode2_low: got %b expected 0", out[1]);
        end
        gate[1] = 1'b0;
        @(negedge clk);
        n_run++;
        if (out[1] !== 1'b1) begin
            n_fail++; $display("FAIL mode2_gate_force: got %b expected 1", out[1]);
        end
        repeat (2) pit_tick();
        read16(3'd1, v);
        n_run++;
        if (v !== 16'h0001) begin
            n_fail++; $display("FAIL mode2_gate_hold: got %h expected 0001", v);
        end
        n_run++;
        if (out[1] !== 1'b1) begin
            n_fail++; $display("FAIL mode2_gate_out: got %b expected 1", out[1]);
        end
        gate[1] = 1'b1;
        pit_tick();
        read16(3'd1, v);
        n_run++;
        if (v !== 16'h0004) begin
            n_fail++; $display("FAIL mode2_gate_reload: got %h expected 0004", v);
        end
    endtask

    task automatic test_mode3();
        logic [15:0] v;
        int          s;
        logic        e;
        bus_write(CTL, 16'h0236);
        bus_write(3'd2, 16'h0005);
        bus_write(3'd2, 16'h0000);
        pit_tick();
        n_run++;
        if (out[2] !== 1'b1) begin
            n_fail++; $display("FAIL mode3_load: got %b expected 1", out[2]);
        end
        for (int i = 0; i < 10; i++) begin
            pit_tick();
            s = 5 - ((i + 1) % 5);
            e = (s > 2) ? 1'b1 : 1'b0;
            n_run++;
            if (out[2] !== e) begin
                n_fail++; $display("FAIL mode3_pattern tick %0d: got %b expected %b", i, out[2], e);
            end
        end
        bus_write(3'd2, 16'h0000);
        bus_write(3'd2, 16'h0000);
        pit_tick();
        read16(3'd2, v);
        n_run++;
        if (v !== 16'h0000) begin
            n_fail++; $display("FAIL mode3_n0_load: got %h expected 0000", v);
        end
        pit_tick();
        read16(3'd2, v);
        n_run++;
        if (v !== 16'hFFFF) begin
            n_fail++; $display("FAIL mode3_n0_count: got %h expected ffff", v);
        end
        n_run++;
        if (out[2] !== 1'b1) begin
            n_fail++; $display("FAIL mode3_n0_out: got %b expected 1", out[2]);
        end
    endtask

    task automatic test_latch();
        logic [15:0] v;
        bus_write(CTL, 16'h0030);
        bus_write(3'd0, 16'h0034);
        bus_write(3'd0, 16'h0012);
        pit_tick();
        bus_write(CTL, 16'h0000);
        repeat (3) pit_tick();
        bus_write(CTL, 16'h0000);
        pit_tick();
        bus_read(3'd0, v);
        n_run++;
        if (v !== 16'h0034) begin
            n_fail++; $display("FAIL latch_lsb: got %h expected 0034", v);
        end
        bus_read(3'd0, v);
        n_run++;
        if (v !== 16'h0012) begin
            n_fail++; $display("FAIL latch_msb: got %h expected 0012", v);
        end
        read16(3'd0, v);
        n_run++;
        if (v !== 16'h1230) begin
            n_fail++; $display("FAIL latch_live: got %h expected 1230", v);
        end
        bus_write(CTL, 16'h0000);
        pit_tick();
        read16(3'd0, v);
        n_run++;
        if (v !== 16'h1230) begin
            n_fail++; $display("FAIL latch_rearm: got %h expected 1230", v);
        end
    endtask

    task automatic test_back_to_back();
        bus_write(CTL, 16'h0130);
        bus_write(3'd1, 16'h00CD);
        bus_write(3'd1, 16'h00AB);
        pit_tick();
        @(negedge clk);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = 3'd1;
        @(negedge clk);
        n_run++;
        if (data_m_ack !== 1'b1 || data_m_data_out !== 16'h00CD) begin
            n_fail++; $display("FAIL b2b_first: got ack %b data %h expected 1 00cd", data_m_ack, data_m_data_out);
        end
        @(negedge clk);
        n_run++;
        if (data_m_ack !== 1'b1 || data_m_data_out !== 16'h00AB) begin
            n_fail++; $display("FAIL b2b_second: got ack %b data %h expected 1 00ab", data_m_ack, data_m_data_out);
        end
        cs = 1'b0; data_m_access = 1'b0;
        @(negedge clk);
        n_run++;
        if (data_m_ack !== 1'b0 || data_m_data_out !== 16'h0000) begin
            n_fail++; $display("FAIL b2b_idle: got ack %b data %h expected 0 0000", data_m_ack, data_m_data_out);
        end
        data_m_access = 1'b1;
        @(negedge clk);
        n_run++;
        if (data_m_ack !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_cs: got ack %b expected 0", data_m_ack);
        end
        data_m_access = 1'b0;
    endtask

    task automatic test_read_tick();
        logic [15:0] v;
        @(negedge clk); pit_clk = 1'b1;
        @(negedge clk);
        @(negedge clk); pit_clk = 1'b0;
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = 3'd1;
        @(negedge clk);
        v = data_m_data_out;
        cs = 1'b0; data_m_access = 1'b0;
        n_run++;
        if (v !== 16'h00CD) begin
            n_fail++; $display("FAIL read_tick_pre: got %h expected 00cd", v);
        end
        @(negedge clk);
        bus_read(3'd1, v);
        n_run++;
        if (v !== 16'h00AB) begin
            n_fail++; $display("FAIL read_tick_msb: got %h expected 00ab", v);
        end
        read16(3'd1, v);
        n_run++;
        if (v !== 16'hABCC) begin
            n_fail++; $display("FAIL read_tick_post: got %h expected abcc", v);
        end
    endtask

    task automatic test_readback();
        logic [15:0] v;
        logic [15:0] e;
        bus_write(CTL, 16'h0216);
        bus_read(CTL, v);
`ifdef PIT_STATUS_READBACK_EN
        e = 16'h0056;
`else
        e = 16'h0000;
`endif
        n_run++;
        if (v !== e) begin
            n_fail++; $display("FAIL readback_status: got %h expected %h", v, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        bus_write(CTL, 16'h0234);
        bus_write(3'd2, 16'h0003);
        bus_write(3'd2, 16'h0000);
        pit_tick();
        n_run++;
        if (out[2] !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_out: got %b expected 1", out[2]);
        end
        @(negedge clk);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = 3'd0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_run++;
        if (out !== 3'b000 || data_m_ack !== 1'b0 || data_m_data_out !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid: got out %b ack %b data %h expected 000 0 0000", out, data_m_ack, data_m_data_out);
        end
        cs = 1'b0; data_m_access = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            read16(3'(c), v);
            n_run++;
            if (v !== 16'h0000) begin
                n_fail++; $display("FAIL reset_read ch%0d: got %h expected 0000", c, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode2();
        test_mode3();
        test_latch();
        test_back_to_back();
        test_read_tick();
        test_readback();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
